// File: rtl/csa32_result_fifo_pkg.sv
// Shared types and constants for the carry-select adder result path.
package csa_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [WORD_W-1:0] SAT_NEG = 32'h8000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] sum;
    logic              cout;
    logic              of;
  } result_t;
endpackage

// File: rtl/csa32_result_fifo_if.sv
// Producer/consumer handshake bundle around the adder result FIFO.
interface csa32_result_fifo_if
  import csa_pkg::*;
#(
  parameter int WIDTH = WORD_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_of;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_of;

  modport master (
    output in_valid, in_sum, in_cout, in_of, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_of
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_of, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_of
  );
endinterface

// File: rtl/csa32_result_fifo_sat.sv
// Combinational clamp of an overflowed two's-complement sum to the nearest extreme.
module csa_sat
  import csa_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic signed [WIDTH-1:0] sum_i,
  input  logic                    of_i,
  output logic signed [WIDTH-1:0] sum_o
);
  localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // A wrapped-negative sign bit means the true result overflowed upward.
  always_comb begin
    sum_o = sum_i;
    if (of_i) sum_o = sum_i[WIDTH-1] ? POS_MAX : NEG_MIN;
  end
endmodule

// File: rtl/csa32_result_fifo.sv
// Result capture FIFO with saturating overflow counter and sticky flag.
// Optional sum clamping of overflowed results is enabled by CSA32_RESULT_SAT_EN.
module csa32_result_fifo
  import csa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  csa32_result_fifo_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           ovf_count,
  output logic                       ovf_sticky
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int ENT_W = WIDTH + 2;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             push, pop;
  logic [WIDTH-1:0] wr_sum;

`ifdef CSA32_RESULT_SAT_EN
  csa_sat #(.WIDTH(WIDTH)) u_sat (
    .sum_i (bus.in_sum),
    .of_i  (bus.in_of),
    .sum_o (wr_sum)
  );
`else
  assign wr_sum = bus.in_sum;
`endif

  // Handshake flags come from level alone, never from the peer's strobes.
  assign bus.in_ready  = (level_q != FULL_LVL);
  assign bus.out_valid = (level_q != '0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  assign {bus.out_sum, bus.out_cout, bus.out_of} = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign ovf_count  = ovf_q;
  assign ovf_sticky = sticky_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (push && bus.in_of) begin
      sticky_d = 1'b1;
      if (ovf_q != '1) ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      sticky_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      if (push) mem_q[wr_ptr_q] <= {wr_sum, bus.in_cout, bus.in_of};
    end
  end
endmodule

// File: doc/csa32_result_fifo.md
# csa32_result_fifo

Downstream capture stage for the 32-bit carry-select adder. Each cycle the adder produces a valid result, this block accepts the sum, carry-out and overflow flag and buffers them in a small FIFO. Results drain to the consumer through a valid/ready handshake. It also keeps a saturating count of overflow events for status readout.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- WIDTH, 32, sum width; matches adder word
- CNT_W, 16, overflow counter width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  adder result present this cycle
- in_ready  out  1  FIFO can accept; equals !full
- in_sum  in  WIDTH  adder sum
- in_cout  in  1  adder carry-out
- in_of  in  1  adder signed-overflow flag
- out_valid  out  1  head entry valid; equals !empty
- out_ready  in  1  consumer takes head this cycle
- out_sum  out  WIDTH  head sum (post-saturation when enabled)
- out_cout  out  1  head carry-out
- out_of  out  1  head overflow flag (original, never altered)
- level  out  $clog2(DEPTH+1)  occupied entries
- ovf_count  out  CNT_W  accepted results with in_of=1, saturating
- ovf_sticky  out  1  set on first accepted overflow, cleared only by rst

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: DEPTH-entry array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. The level counter gives full/empty: full = (level==DEPTH), empty = (level==0).
- Push writes {sum, cout, of} at wr_ptr, then wr_ptr+1. Pop advances rd_ptr.
- Level update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Full: in_ready=0. Any in_valid is ignored: no write, no count update, and no pop-frees-slot bypass. The producer must hold or drop the result.
- Empty: out_valid=0, and out_ready is ignored. out_* shows mem[rd_ptr], which is don't-care.
- Simultaneous push and pop at level 1: the head pops, the new entry becomes the head, and level stays 1.
- ovf_count increments by 1 on each push with in_of=1. It holds at all-ones (no wrap). Pops do not affect it.
- ovf_sticky is set on the first push with in_of=1.
- Reset (at any time, including mid-stream):
  - pointers, level, ovf_count, ovf_sticky and all storage are cleared to 0
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_of=0
  - in-flight entries are discarded

## Timing
- Registered state only; out_* is a combinational read of the head register.
- Latency: a push in cycle N gives out_valid=1 with that data in cycle N+1, if the FIFO was empty.
- in_ready and out_valid depend only on level, never combinationally on in_valid or out_ready.
- level, ovf_count and ovf_sticky update on the clk edge that completes the push or pop.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- CSA32_RESULT_SAT_EN defined:
  - a pushed entry with in_of=1 stores a clamped sum
  - in_sum[WIDTH-1]=1 (positive overflow) stores 0x7FFFFFFF
  - in_sum[WIDTH-1]=0 (negative overflow) stores 0x80000000
  - in_cout and in_of are stored unchanged
- Not defined: in_sum is stored verbatim.
- Counter and sticky behaviour are identical in both builds.

## Structure
- Package csa_pkg:
  - WORD_W=32
  - SAT_POS (0x7FFFFFFF) and SAT_NEG (0x80000000)
  - result typedef {sum[WORD_W-1:0], cout, of}, shared with the adder wrapper and the bench
- Sub-module csa_sat: combinational clamp, inputs sum and of, output clamped sum. It is instantiated only under CSA32_RESULT_SAT_EN; otherwise a pass-through assign is used.

## Test plan
- Reset, then idle:
  - required: in_ready=1, out_valid=0, level=0, ovf_count=0, out_sum=0
- Single push of sum=0x000007A9, cout=1, of=0, with out_ready=0:
  - next cycle: out_valid=1, out_sum=0x000007A9, out_cout=1, level=1
  - raise out_ready for one cycle: level returns to 0
- Fill and wrap:
  - push 5 results 0x15F, 0xFFFFFFFE, 0xFFFFF246, 0xFFFFFAAA, 0xFFFFFFFF with out_ready=0
  - required: in_ready=0 after the 4th push; the 5th is dropped; level=4
  - then drain: out order is 0x15F, 0xFFFFFFFE, 0xFFFFF246, 0xFFFFFAAA
  - refill 4 more: checks pointer wrap
- Concurrent push and pop at level 1 for 10 cycles with alternating data:
  - required: level stays 1 and each output equals the value pushed the previous cycle
- Overflow push of sum=0xFFFFFFFE, of=1:
  - with CSA32_RESULT_SAT_EN: out_sum=0x7FFFFFFF, out_of=1
  - without: out_sum=0xFFFFFFFE
  - in both builds: ovf_count=1, ovf_sticky=1
- Counter and mid-stream reset:
  - force ovf_count to 0xFFFF via 65536 overflow pushes (pop each): counter holds at 0xFFFF
  - assert rst with level=3: next cycle level=0, out_valid=0, ovf_count=0, ovf_sticky=0
